// File: rtl/ber_checker.sv
// Receive-side bit-error-rate checker: tries every candidate Tx->Rx latency over one
// PRBS period, locks to the one with the fewest errors, then counts bits and errors.
module ber_checker #(
  parameter int ORDER   = 9,
  parameter int MAX_LAT = 16,
  parameter int LAT_W   = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_restart,
  input  logic             i_bit_tx,
  input  logic             i_bit_rx,
  output logic             o_lock,
  output logic [LAT_W-1:0] o_latency,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int               WIN       = (2 ** ORDER) - 1;
  localparam logic [ORDER-1:0] WIN_LAST  = ORDER'(WIN - 1);
  localparam logic [LAT_W-1:0] CAND_LAST = LAT_W'(MAX_LAT - 1);
  localparam logic [ORDER-1:0] ACC_MAX   = {ORDER{1'b1}};

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCK   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAX_LAT-2:0] r_hist;
  logic [MAX_LAT-1:0] w_hist;
  logic [LAT_W-1:0]   r_cand;
  logic [ORDER-1:0]   r_acc;
  logic [ORDER-1:0]   r_win_cnt;
  logic [ORDER-1:0]   r_best_err;
  logic [LAT_W-1:0]   r_best_lat;
  logic               r_lock;
  logic [LAT_W-1:0]   r_latency;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_err_cand;
  logic               w_err_lock;
  logic [ORDER-1:0]   w_acc_final;
  logic               w_win_done;
  logic               w_better;
  logic               w_search_done;
  logic               w_cnt_sat;

  // hist[0] is the live tx bit; older bits come from the shift register
  assign w_hist        = {r_hist, i_bit_tx};
  assign w_err_cand    = i_bit_rx ^ w_hist[r_cand];
  assign w_err_lock    = i_bit_rx ^ w_hist[r_latency];
  assign w_acc_final   = r_acc + {{(ORDER-1){1'b0}}, w_err_cand};
  assign w_win_done    = (r_win_cnt == WIN_LAST);
  assign w_better      = (w_acc_final < r_best_err);
  assign w_search_done = w_win_done && (r_cand == CAND_LAST);
  assign w_cnt_sat     = &r_bit_cnt;

  assign o_lock    = r_lock;
  assign o_latency = r_latency;
  assign o_bit_cnt = r_bit_cnt;
  assign o_err_cnt = r_err_cnt;

  // Next-state decode; restart overrides any strobe on the same clock
  always_comb begin
    w_state_nxt = r_state;
    if (i_restart) begin
      w_state_nxt = ST_SEARCH;
    end else if (i_enable) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_search_done) begin
            w_state_nxt = ST_LOCK;
          end else begin
            w_state_nxt = ST_SEARCH;
          end
        end
        ST_LOCK:   w_state_nxt = ST_LOCK;
        default:   w_state_nxt = ST_SEARCH;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State register
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // History, search accumulators and lock-phase counters
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_hist     <= '0;
      r_cand     <= '0;
      r_acc      <= '0;
      r_win_cnt  <= '0;
      r_best_err <= ACC_MAX;
      r_best_lat <= '0;
      r_lock     <= 1'b0;
      r_latency  <= '0;
      r_bit_cnt  <= '0;
      r_err_cnt  <= '0;
    end else if (i_restart) begin
      // latency and history survive a restart
      r_cand     <= '0;
      r_acc      <= '0;
      r_win_cnt  <= '0;
      r_best_err <= ACC_MAX;
      r_best_lat <= '0;
      r_lock     <= 1'b0;
      r_bit_cnt  <= '0;
      r_err_cnt  <= '0;
    end else if (i_enable) begin
      r_hist <= w_hist[MAX_LAT-2:0];
      case (r_state)
        ST_SEARCH: begin
          if (w_win_done) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
            r_cand    <= r_cand + {{(LAT_W-1){1'b0}}, 1'b1};
            if (w_better) begin
              r_best_err <= w_acc_final;
              r_best_lat <= r_cand;
            end
            if (w_search_done) begin
              r_lock    <= 1'b1;
              r_latency <= w_better ? r_cand : r_best_lat;
            end
          end else begin
            r_acc     <= w_acc_final;
            r_win_cnt <= r_win_cnt + {{(ORDER-1){1'b0}}, 1'b1};
          end
        end
        ST_LOCK: begin
          // both counters freeze together so the error ratio stays meaningful
          if (!w_cnt_sat) begin
            r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, w_err_lock};
          end
        end
        default: begin
          r_lock <= 1'b0;
        end
      endcase
    end
  end

endmodule
